serial_link_master: RTL

- Hardware bus initiator for the serial_gen2 register port. It lets fabric logic move bytes over the UART without a CPU.
- At reset it programs the clock divider. It then polls status, drains received bytes onto an output stream, and pushes bytes from an input stream into the TX queue.
- It tracks the peripheral's overwrite flags, which clear on read, as sticky error bits.
- It sits between the programmer's command engine and serial_gen2.

---
 rtl/serial_link_master.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/serial_link_master.sv
// serial_gen2 bus initiator: programs the divider, polls status and
// moves bytes between the fabric streams and the UART register port.
`timescale 1ns/1ps

module serial_link_master #(
    parameter logic [15:0] DEFAULT_DIV = 16'd434,
    parameter int          POLL_GAP    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  bus_addr,
    output logic        bus_en,
    output logic        bus_wren,
    output logic        bus_ren,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic [15:0] cfg_div,
    input  logic        cfg_load,
    input  logic        tx_valid,
    input  logic [7:0]  tx_byte,
    output logic        tx_accept,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    input  logic        rx_ack,
    output logic        tx_err,
    output logic        rx_err,
    input  logic        err_clear,
    output logic        cfg_busy
);

    typedef enum logic [3:0] {
        CFG_L, CFG_H, GAP, POLL, PWAIT, PCAP, RD, RWAIT, RCAP, WR
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    localparam logic [1:0] A_DATA = 2'b00;
    localparam logic [1:0] A_STAT = 2'b01;
    localparam logic [1:0] A_DIVL = 2'b10;
    localparam logic [1:0] A_DIVH = 2'b11;

    state_t      state_q, state_d;
    state_t      gap_entry;
    logic [15:0] div_q;
    logic [7:0]  div_hi_q;
    logic        pend_q;
    logic [7:0]  gap_cnt_q;
    logic        tx_full_q;
    logic [7:0]  tx_hold_q;
    logic        last_rd_q;

    logic [1:0]  addr_d;
    logic [7:0]  wdata_d;
    logic        en_d, wren_d, ren_d;
    logic        rx_load, tx_drain;
    logic        set_txe, set_rxe;
    logic        serve_rd, serve_wr;
    logic        rd_ok, wr_ok;
    logic        cfg_start;

    assign tx_accept = tx_valid & ~tx_full_q & reset_n;
    assign cfg_start = (state_d == CFG_L) && (state_q != CFG_L);

    // Each state decides the bus cycle that appears one clock later.
    always_comb begin
        state_d  = state_q;
        addr_d   = bus_addr;
        wdata_d  = bus_wdata;
        en_d     = 1'b0;
        wren_d   = 1'b0;
        ren_d    = 1'b0;
        rx_load  = 1'b0;
        tx_drain = 1'b0;
        set_txe  = 1'b0;
        set_rxe  = 1'b0;
        serve_rd = 1'b0;
        serve_wr = 1'b0;
        rd_ok    = bus_rdata[3] & ~rx_valid;
        wr_ok    = bus_rdata[2] & tx_full_q;
        if (POLL_GAP == 0) begin
            gap_entry = pend_q ? CFG_L : POLL;
        end else begin
            gap_entry = GAP;
        end

        unique case (state_q)
            CFG_L: begin
                en_d    = 1'b1;
                wren_d  = 1'b1;
                addr_d  = A_DIVL;
                wdata_d = div_q[7:0];
                state_d = CFG_H;
            end
            CFG_H: begin
                en_d    = 1'b1;
                wren_d  = 1'b1;
                addr_d  = A_DIVH;
                wdata_d = div_hi_q;
                state_d = gap_entry;
            end
            GAP: begin
                if (pend_q) begin
                    state_d = CFG_L;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d = POLL;
                end
            end
            POLL: begin
                en_d    = 1'b1;
                ren_d   = 1'b1;
                addr_d  = A_STAT;
                state_d = PWAIT;
            end
            PWAIT: state_d = PCAP;
            PCAP: begin
                set_txe = bus_rdata[0];
                set_rxe = bus_rdata[1];
                if (rd_ok && (!wr_ok || !last_rd_q)) begin
                    serve_rd = 1'b1;
                    state_d  = RD;
                end else if (wr_ok) begin
                    serve_wr = 1'b1;
                    state_d  = WR;
                end else begin
                    state_d  = gap_entry;
                end
            end
            RD: begin
                en_d    = 1'b1;
                ren_d   = 1'b1;
                addr_d  = A_DATA;
                state_d = RWAIT;
            end
            RWAIT: state_d = RCAP;
            RCAP: begin
                rx_load = 1'b1;
                state_d = gap_entry;
            end
            WR: begin
                en_d     = 1'b1;
                wren_d   = 1'b1;
                addr_d   = A_DATA;
                wdata_d  = tx_hold_q;
                tx_drain = 1'b1;
                state_d  = gap_entry;
            end
            default: state_d = CFG_L;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CFG_L;
            bus_addr  <= 2'b00;
            bus_en    <= 1'b0;
            bus_wren  <= 1'b0;
            bus_ren   <= 1'b0;
            bus_wdata <= 8'h00;
            cfg_busy  <= 1'b1;
            div_q     <= DEFAULT_DIV;
            div_hi_q  <= 8'h00;
            pend_q    <= 1'b0;
            gap_cnt_q <= 8'h00;
            tx_full_q <= 1'b0;
            tx_hold_q <= 8'h00;
            rx_valid  <= 1'b0;
            rx_byte   <= 8'h00;
            tx_err    <= 1'b0;
            rx_err    <= 1'b0;
            last_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_addr  <= addr_d;
            bus_en    <= en_d;
            bus_wren  <= wren_d;
            bus_ren   <= ren_d;
            bus_wdata <= wdata_d;
            cfg_busy  <= (state_q == CFG_L) || (state_q == CFG_H);
            gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 8'd1 : 8'd0;

            // High byte frozen at CFG_L so a late cfg_load cannot mix halves.
            if (state_q == CFG_L) begin
                div_hi_q <= div_q[15:8];
            end
            if (cfg_load) begin
                div_q  <= cfg_div;
                pend_q <= 1'b1;
            end else if (cfg_start) begin
                pend_q <= 1'b0;
            end

            if (tx_accept) begin
                tx_full_q <= 1'b1;
                tx_hold_q <= tx_byte;
            end else if (tx_drain) begin
                tx_full_q <= 1'b0;
            end

            if (rx_load) begin
                rx_valid <= 1'b1;
                rx_byte  <= bus_rdata;
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end

            if (set_txe) begin
                tx_err <= 1'b1;
            end else if (err_clear) begin
                tx_err <= 1'b0;
            end
            if (set_rxe) begin
                rx_err <= 1'b1;
            end else if (err_clear) begin
                rx_err <= 1'b0;
            end

            if (serve_rd) begin
                last_rd_q <= 1'b1;
            end else if (serve_wr) begin
                last_rd_q <= 1'b0;
            end
        end
    end

endmodule
